// File: rtl/sign_mutex_classifier.sv
// sign_mutex_classifier
// Per-channel sign classifier with debounced, mutually exclusive
// POS/NEG/ZERO flags and a saturating sign-crossing counter per channel.
//
// Handshake: in_valid qualifies in_data for exactly one cycle and there is
// no backpressure (no ready). out_valid is in_valid registered by one clock
// and rises together with the flags/counts that the sample produced.
module sign_mutex_classifier #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      clr_cnt,
    output logic [CHANNELS-1:0]       positive_flag,
    output logic [CHANNELS-1:0]       negative_flag,
    output logic [CHANNELS-1:0]       zero_flag,
    output logic                      out_valid,
    output logic [CHANNELS*CNT_W-1:0] cross_cnt
);

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_POS  = 2'd1,
        CLS_NEG  = 2'd2
    } cls_t;

    typedef enum logic [1:0] {
        SGN_NONE = 2'd0,
        SGN_POS  = 2'd1,
        SGN_NEG  = 2'd2
    } sgn_t;

    // Complete per-channel state in one struct so it can be probed
    // hierarchically (ch_q[c]) without extra ports.
    typedef struct packed {
        cls_t             cand;
        logic [3:0]       run;
        cls_t             stable;
        sgn_t             last;
        logic [CNT_W-1:0] cnt;
    } chan_t;

    localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chan_t ch_q [CHANNELS];
    chan_t ch_d [CHANNELS];

    function automatic cls_t classify(input logic [WIDTH-1:0] s);
        if (s[WIDTH-1])
            return CLS_NEG;
        else if (s == '0)
            return CLS_ZERO;
        else
            return CLS_POS;
    endfunction

    // One channel's next state. The stable class follows the candidate only
    // once the updated run reaches DEBOUNCE; crossings are counted only on
    // POS<->NEG stable changes, passing through ZERO does not reset last-sign.
    function automatic chan_t next_chan(input chan_t cur, input cls_t raw,
                                        input logic valid, input logic clr);
        chan_t nxt;
        nxt = cur;
        if (valid) begin
            if (raw == cur.cand) begin
                if (cur.run < DEB)
                    nxt.run = cur.run + 4'd1;
            end else begin
                nxt.cand = raw;
                nxt.run  = 4'd1;
            end
            if (nxt.run == DEB && nxt.cand != cur.stable) begin
                nxt.stable = nxt.cand;
                if (nxt.cand == CLS_POS) begin
                    if (cur.last == SGN_NEG && cur.cnt != CNT_MAX)
                        nxt.cnt = cur.cnt + CNT_W'(1);
                    nxt.last = SGN_POS;
                end else if (nxt.cand == CLS_NEG) begin
                    if (cur.last == SGN_POS && cur.cnt != CNT_MAX)
                        nxt.cnt = cur.cnt + CNT_W'(1);
                    nxt.last = SGN_NEG;
                end
            end
        end
        // Clear has priority over any increment computed above.
        if (clr)
            nxt.cnt = '0;
        return nxt;
    endfunction

    // Next-state for every channel; channels never look at each other.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ch_d[c] = next_chan(ch_q[c], classify(in_data[c*WIDTH +: WIDTH]),
                                in_valid, clr_cnt);
        end
    end

    // State registers with asynchronous reset to ZERO / NONE / empty counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ch_q[c].cand   <= CLS_ZERO;
                ch_q[c].run    <= 4'd0;
                ch_q[c].stable <= CLS_ZERO;
                ch_q[c].last   <= SGN_NONE;
                ch_q[c].cnt    <= '0;
            end
            out_valid <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                ch_q[c] <= ch_d[c];
            end
            out_valid <= in_valid;
        end
    end

    // Flags decode the registered stable class, so exactly one is set.
    always_comb begin
        positive_flag = '0;
        negative_flag = '0;
        zero_flag     = '0;
        cross_cnt     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            positive_flag[c]           = (ch_q[c].stable == CLS_POS);
            negative_flag[c]           = (ch_q[c].stable == CLS_NEG);
            zero_flag[c]               = (ch_q[c].stable == CLS_ZERO);
            cross_cnt[c*CNT_W +: CNT_W] = ch_q[c].cnt;
        end
    end

endmodule

// File: tb/tb_sign_mutex_classifier.sv
// Bench for sign_mutex_classifier: a default instance and a CNT_W=2
// instance share all inputs; a reference model predicts flags and counts.
module tb_sign_mutex_classifier;

    localparam int DEB = 3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [63:0] in_data = '0;

    always #5 clk = ~clk;

    logic [3:0]  pos_a, neg_a, zero_a;
    logic        ov_a;
    logic [31:0] cnt_a;
    logic [3:0]  pos_b, neg_b, zero_b;
    logic        ov_b;
    logic [7:0]  cnt_b;

    sign_mutex_classifier dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clr_cnt(clr_cnt), .positive_flag(pos_a), .negative_flag(neg_a),
        .zero_flag(zero_a), .out_valid(ov_a), .cross_cnt(cnt_a)
    );

    sign_mutex_classifier #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clr_cnt(clr_cnt), .positive_flag(pos_b), .negative_flag(neg_b),
        .zero_flag(zero_b), .out_valid(ov_b), .cross_cnt(cnt_b)
    );

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    localparam logic [63:0] RESET_VEC = {4'h0, 4'h0, 4'hF, 32'h0, 4'h0, 4'h0, 4'hF, 8'h0};

    // Reference model: trailing run of equal raw classes per channel.
    int m_prev [4];
    int m_run  [4];
    int m_stab [4];   // 0 zero, 1 pos, 2 neg
    int m_sign [4];   // 0 none, 1 pos, 2 neg
    int m_ca   [4];
    int m_cb   [4];

    function automatic int cls16(input logic [15:0] s);
        if (s[15]) return 2;
        if (s == 16'h0) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_prev[c] = 0; m_run[c] = 0; m_stab[c] = 0;
            m_sign[c] = 0; m_ca[c] = 0; m_cb[c] = 0;
        end
    endtask

    task automatic model_step(input logic [63:0] d, input logic v, input logic c_clr);
        int r;
        if (v) begin
            for (int c = 0; c < 4; c++) begin
                r = cls16(d[c*16 +: 16]);
                if (r == m_prev[c]) m_run[c]++;
                else begin m_prev[c] = r; m_run[c] = 1; end
                if (m_run[c] >= DEB && r != m_stab[c]) begin
                    m_stab[c] = r;
                    if (r != 0) begin
                        if (m_sign[c] != 0 && m_sign[c] != r) begin
                            if (m_ca[c] < 255) m_ca[c]++;
                            if (m_cb[c] < 3)   m_cb[c]++;
                        end
                        m_sign[c] = r;
                    end
                end
            end
        end
        if (c_clr) begin
            for (int c = 0; c < 4; c++) begin m_ca[c] = 0; m_cb[c] = 0; end
        end
    endtask

    function automatic logic [63:0] model_vec();
        logic [3:0]  p, n, z;
        logic [31:0] ca;
        logic [7:0]  cb;
        for (int c = 0; c < 4; c++) begin
            p[c] = (m_stab[c] == 1);
            n[c] = (m_stab[c] == 2);
            z[c] = (m_stab[c] == 0);
            ca[c*8 +: 8] = 8'(m_ca[c]);
            cb[c*2 +: 2] = 2'(m_cb[c]);
        end
        return {p, n, z, ca, p, n, z, cb};
    endfunction

    function automatic logic [63:0] obs_vec();
        return {pos_a, neg_a, zero_a, cnt_a, pos_b, neg_b, zero_b, cnt_b};
    endfunction

    function automatic logic [63:0] with_ch(input logic [63:0] b, input int c,
                                            input logic [15:0] v);
        b[c*16 +: 16] = v;
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled at the falling edge; an entry in exp_q means the
    // previous cycle carried a valid sample.
    task automatic check_out(input string tag);
        logic        expv;
        logic [63:0] e;
        expv = (exp_q.size() != 0);
        check({tag, "/out_valid"}, {62'b0, ov_a, ov_b}, {62'b0, expv, expv});
        if (expv) begin
            e = exp_q.pop_front();
            check(tag, obs_vec(), e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic v, input logic [63:0] d, input logic c_clr,
                        input string tag);
        @(negedge clk);
        check_out(tag);
        #1;
        in_valid = v;
        in_data  = d;
        clr_cnt  = c_clr;
        model_step(d, v, c_clr);
        if (v) exp_q.push_back(model_vec());
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            tick(1'b0, {$urandom, $urandom}, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag, input bit pre_check);
        @(negedge clk);
        if (pre_check) check_out(tag);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        #1;
        check({tag, "/async_state"}, obs_vec(), RESET_VEC);
        check({tag, "/async_ov"}, {62'b0, ov_a, ov_b}, 64'h0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    logic [63:0] bg;
    logic [15:0] seq_vals [4];
    logic [15:0] pool [6];
    logic [15:0] cur_v [4];
    logic        rv, rc;
    logic [63:0] rd;

    initial begin
        model_reset();

        // reset then idle
        do_reset("reset", 1'b0);
        idle(10, "idle");
        check("idle_state", obs_vec(), RESET_VEC);

        // debounce with a glitch restarting the run on ch0
        bg = 64'h0;
        tick(1'b1, with_ch(bg, 0, 16'h0005), 1'b0, "deb_s1");
        tick(1'b1, with_ch(bg, 0, 16'h0005), 1'b0, "deb_s2");
        tick(1'b1, with_ch(bg, 0, 16'h8000), 1'b0, "deb_glitch");
        tick(1'b1, with_ch(bg, 0, 16'h0005), 1'b0, "deb_r1");
        tick(1'b1, with_ch(bg, 0, 16'h0005), 1'b0, "deb_r2");
        tick(1'b1, with_ch(bg, 0, 16'h0005), 1'b0, "deb_r3");
        check("deb_not_early", {63'b0, pos_a[0]}, 64'h0);
        idle(1, "deb_idle");
        check("deb_rise", {60'b0, pos_a}, 64'h1);

        // crossing sequence on ch1, ch0 held positive
        bg = with_ch(64'h0, 0, 16'h0005);
        seq_vals[0] = 16'h0001; seq_vals[1] = 16'hFFFF;
        seq_vals[2] = 16'h0000; seq_vals[3] = 16'h7FFF;
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 3; r++)
                tick(1'b1, with_ch(bg, 1, seq_vals[k]), 1'b0, "cross");
        idle(1, "cross_idle");
        check("cross_cnt_ch1", {56'b0, cnt_a[15:8]}, 64'd2);
        check("cross_final_pos", {63'b0, pos_a[1]}, 64'h1);

        // saturation on ch2, then clear on an incrementing edge
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < 3; r++) tick(1'b1, with_ch(bg, 2, 16'h0100), 1'b0, "sat_pos");
            for (int r = 0; r < 3; r++) tick(1'b1, with_ch(bg, 2, 16'hC000), 1'b0, "sat_neg");
        end
        idle(1, "sat_idle");
        check("sat_narrow", {62'b0, cnt_b[5:4]}, 64'd3);
        check("sat_wide", {56'b0, cnt_a[23:16]}, 64'd9);
        tick(1'b1, with_ch(bg, 2, 16'h0100), 1'b0, "clr_p1");
        tick(1'b1, with_ch(bg, 2, 16'h0100), 1'b0, "clr_p2");
        tick(1'b1, with_ch(bg, 2, 16'h0100), 1'b1, "clr_p3");
        idle(1, "clr_idle");
        check("clr_wide", {32'b0, cnt_a}, 64'h0);
        check("clr_narrow", {56'b0, cnt_b}, 64'h0);
        check("clr_keeps_stable", {63'b0, pos_a[2]}, 64'h1);
        for (int r = 0; r < 3; r++) tick(1'b1, with_ch(bg, 2, 16'hC000), 1'b0, "post_clr");
        idle(1, "post_clr_idle");
        check("clr_keeps_last_sign", {56'b0, cnt_a[23:16]}, 64'd1);

        // gaps between valid samples on ch3
        tick(1'b1, with_ch(bg, 3, 16'h0009), 1'b0, "gap_s1");
        idle(5, "gap_idle1");
        tick(1'b1, with_ch(bg, 3, 16'h0009), 1'b0, "gap_s2");
        idle(1, "gap_idle2");
        tick(1'b1, with_ch(bg, 3, 16'h0009), 1'b0, "gap_s3");
        check("gap_not_early", {63'b0, pos_a[3]}, 64'h0);
        idle(1, "gap_idle3");
        check("gap_rise", {63'b0, pos_a[3]}, 64'h1);

        // async reset in the middle of a NEG run on ch0
        tick(1'b1, with_ch(bg, 0, 16'h8000), 1'b0, "mid_n1");
        tick(1'b1, with_ch(bg, 0, 16'h8000), 1'b0, "mid_n2");
        do_reset("mid_reset", 1'b1);
        tick(1'b1, with_ch(bg, 0, 16'h8000), 1'b0, "post_n1");
        tick(1'b1, with_ch(bg, 0, 16'h8000), 1'b0, "post_n2");
        idle(1, "post_idle");
        check("post_reset_zero", {62'b0, zero_a[0], neg_a[0]}, 64'h2);

        // random phase: sticky per-channel values, occasional clears
        pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h0005;
        pool[3] = 16'h7FFF; pool[4] = 16'h8000; pool[5] = 16'hFFFF;
        for (int c = 0; c < 4; c++) cur_v[c] = pool[$urandom_range(0, 5)];
        for (int i = 0; i < 120; i++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 3) == 0) cur_v[c] = pool[$urandom_range(0, 5)];
            rd = {cur_v[3], cur_v[2], cur_v[1], cur_v[0]};
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 19) == 0);
            tick(rv, rd, rc, "random");
        end
        idle(2, "drain");
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sign_mutex_classifier.md
SIGN_MUTEX_CLASSIFIER -- requirements
Module: sign_mutex_classifier

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- WIDTH, 16: bits per channel sample, two's complement.
- CHANNELS, 4: number of independent channels.
- DEBOUNCE, 3: consecutive equal-class samples needed to change a flag; legal range 1..15.
- CNT_W, 8: width of each per-channel sign-crossing counter.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  qualifies in_data for one cycle.
- in_data  in  CHANNELS*WIDTH  samples; channel c occupies bits [c*WIDTH +: WIDTH].
- clr_cnt  in  1  synchronous clear of all crossing counters.
- positive_flag  out  CHANNELS  bit c is 1 when channel c's stable class is POS.
- negative_flag  out  CHANNELS  bit c is 1 when channel c's stable class is NEG.
- zero_flag  out  CHANNELS  bit c is 1 when channel c's stable class is ZERO.
- out_valid  out  1  one-cycle pulse, registered copy of in_valid.
- cross_cnt  out  CHANNELS*CNT_W  per-channel saturating sign-crossing counts, packed like in_data.

Function
REQ-003 Raw class per channel SHALL be computed as follows:
- NEG if the sample MSB is 1.
- ZERO if all sample bits are 0.
- POS otherwise.
REQ-004 Each channel SHALL hold these registers:
- a candidate class;
- a run counter, 4 bits;
- a stable class;
- a last-sign register, with values NONE, POS or NEG;
- a crossing counter.
REQ-005 When in_valid is 0, no channel register SHALL change, except counters cleared by clr_cnt.
REQ-006 On a valid sample whose raw class equals the candidate, the run counter SHALL increment, saturating at DEBOUNCE.
REQ-007 On a valid sample whose raw class differs from the candidate, the candidate SHALL take the raw class and the run counter SHALL be set to 1.
REQ-008 The stable class SHALL update on the same edge where the updated run counter equals DEBOUNCE and the updated candidate differs from the current stable class.
REQ-009 Consequence of REQ-006..008: a flag change is visible in the cycle after the DEBOUNCE-th consecutive equal-class valid sample is captured.
REQ-010 With DEBOUNCE=1, every valid sample SHALL update the flags on the next edge, with no debounce.
REQ-011 The flags SHALL decode the stable class combinationally from registers, with exactly one of positive/negative/zero set per channel at all times (mutual exclusion).
REQ-012 When stable changes to POS or NEG:
- The crossing counter SHALL increment if last-sign holds the opposite sign.
- Last-sign SHALL then take the new sign.
- Transitions into ZERO SHALL leave last-sign and the counter unchanged.
REQ-013 The crossing counter SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-014 When clr_cnt is 1, all crossing counters SHALL be 0 on the next edge; clr_cnt SHALL win over a simultaneous increment.
REQ-015 clr_cnt SHALL NOT affect candidate, run, stable or last-sign.
REQ-016 Channels SHALL be fully independent; a sample that changes one channel's class SHALL NOT affect any other channel.
REQ-017 out_valid SHALL equal in_valid delayed by one clock.

Reset
REQ-018 While rst is 1, the block SHALL immediately and asynchronously set:
- stable = ZERO, candidate = ZERO, run = 0, last-sign = NONE;
- cross_cnt = 0, out_valid = 0;
- positive_flag = 0, negative_flag = 0, zero_flag = all ones.
REQ-019 On reset asserted mid-debounce, partial run progress SHALL be discarded; after release, DEBOUNCE fresh valid samples are needed to change any flag.

Verification
(Defaults: WIDTH=16, CHANNELS=4, DEBOUNCE=3, CNT_W=8.)
REQ-020 Reset then idle: rst pulse, in_valid=0 for 10 cycles -> zero_flag=4'hF, positive_flag=negative_flag=0, cross_cnt=0, out_valid=0.
REQ-021 Debounce: ch0 gets 16'h0005 on 3 consecutive valid cycles -> positive_flag[0] rises one edge after the 3rd sample, not before; a 16'h8000 glitch after 2 samples restarts the run.
REQ-022 Crossing: ch1 sequence 3x16'h0001, 3x16'hFFFF, 3x16'h0000, 3x16'h7FFF -> cross_cnt ch1 = 2, with the final state positive.
REQ-023 Saturation and clear: CNT_W=2 build; alternate 3xPOS/3xNEG on ch2 five times -> cross_cnt stays 3; clr_cnt asserted on an incrementing edge -> count 0.
REQ-024 Gaps: valid samples 16'h0009, idle 5 cycles, 16'h0009, idle, 16'h0009 on ch3 -> positive_flag[3] sets (idle cycles do not break the run); out_valid pulses once per sample.
REQ-025 Async reset mid-run: 2 NEG samples on ch0, rst asserted between edges -> flags reset immediately without waiting for a clock edge; after release, 2 NEG samples leave zero_flag[0]=1.
